// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: FSM states,
// EX-stage Control bit positions that decode into Start/OpDiv/OpUnsigned.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int CTRL_UNSIGNED_BIT = 0;
    localparam int CTRL_MULT_BIT     = 3;
    localparam int CTRL_DIV_BIT      = 4;

    function automatic bit bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply on {acc,lo} or restoring
// divide on {rem,quotient}. Zero latency, no flow control.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             op_div,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        sum   = {1'b0, acc_in} + (lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        trial = {acc_in, lo_in[WIDTH-1]};
        fits  = (trial >= {1'b0, opnd});
        if (op_div) begin
            // Partial remainder stays below the divisor, so the low WIDTH bits suffice.
            acc_out = fits ? (trial[WIDTH-1:0] - opnd) : trial[WIDTH-1:0];
            lo_out  = {lo_in[WIDTH-2:0], fits};
        end else begin
            acc_out = sum[WIDTH:1];
            lo_out  = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; result N+2 edges after PREP entry.
// Stall asserts while busy whenever the pipeline touches HI/LO or issues a new op.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             OpDiv,
    input  logic             OpUnsigned,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic             Cancel,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (!bpc_legal(BITS_PER_CYCLE) || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("muldiv_sequencer: unsupported BITS_PER_CYCLE");
    end

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, wlo, opnd;
    logic             is_div, is_uns, neg_lo, neg_hi, dbz, ovf;
    logic             idle_like, launch;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign launch    = idle_like & Start & ~Cancel;
    assign Busy      = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);
    assign Stall     = Busy & (Start | ReadHiLo | HiWrite | LoWrite);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = launch ? ST_PREP : ST_IDLE;
            ST_PREP:          state_nxt = Cancel ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (Cancel)        state_nxt = ST_IDLE;
                else if (cnt == 0) state_nxt = ST_FIX;
            end
            ST_FIX:           state_nxt = Cancel ? ST_IDLE : ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Iteration chain: BITS_PER_CYCLE steps per clock.
    logic [WIDTH-1:0] acc_c [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] lo_c  [BITS_PER_CYCLE+1];
    assign acc_c[0] = acc;
    assign lo_c[0]  = wlo;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .op_div  (is_div),
            .opnd    (opnd),
            .acc_in  (acc_c[i]),
            .lo_in   (lo_c[i]),
            .acc_out (acc_c[i+1]),
            .lo_out  (lo_c[i+1])
        );
    end

    // PREP: operands were latched raw as wlo=Op1, opnd=Op2.
    logic             s1, s2;
    logic [WIDTH-1:0] a_abs, b_abs;
    always_comb begin
        s1    = ~is_uns & wlo[WIDTH-1];
        s2    = ~is_uns & opnd[WIDTH-1];
        a_abs = s1 ? -wlo  : wlo;
        b_abs = s2 ? -opnd : opnd;
    end

    // FIX: the multiply product is negated as one 2*WIDTH value.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, res_hi, res_lo;
    always_comb begin
        prod_fix = neg_lo ? -{acc, wlo} : {acc, wlo};
        q_fix    = neg_lo ? -wlo : wlo;
        r_fix    = neg_hi ? -acc : acc;
        if (dbz) q_fix = {WIDTH{1'b1}};
        if (ovf) begin
            q_fix = MOST_NEG;
            r_fix = '0;
        end
        res_hi = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo = is_div ? q_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            acc       <= '0;
            wlo       <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            is_uns    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (HiWrite) Hi <= Op1;
                    if (LoWrite) Lo <= Op1;
                    if (launch) begin
                        wlo    <= Op1;
                        opnd   <= Op2;
                        is_div <= OpDiv;
                        is_uns <= OpUnsigned;
                        acc    <= '0;
                    end
                end
                ST_PREP: begin
                    wlo    <= is_div ? a_abs : b_abs;
                    opnd   <= is_div ? b_abs : a_abs;
                    acc    <= '0;
                    cnt    <= CW'(N - 1);
                    neg_lo <= s1 ^ s2;
                    neg_hi <= is_div ? s1 : (s1 ^ s2);
                    dbz    <= is_div & (opnd == '0);
                    ovf    <= is_div & ~is_uns & (wlo == MOST_NEG) & (&opnd);
                end
                ST_RUN: begin
                    acc <= acc_c[BITS_PER_CYCLE];
                    wlo <= lo_c[BITS_PER_CYCLE];
                    cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    if (!Cancel) begin
                        Hi        <= res_hi;
                        Lo        <= res_lo;
                        Done      <= 1'b1;
                        DivByZero <= dbz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
